// File: rtl/pong_pkg.sv
// ============================================================================
// Module      : pong_pkg
// Description : Shared encodings for the pong ball-collision controller.
//               Holds the direction codes, the 3-bit collision codes, the
//               controller state enum and a saturating subtract helper.
//               The ball-motion block takes a 3-bit collision_type input so
//               that it matches these codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

    // Direction: bit1 = rightward, bit0 = downward
    localparam logic [1:0] c_DIR_UP_LEFT    = 2'b00;
    localparam logic [1:0] c_DIR_DOWN_LEFT  = 2'b01;
    localparam logic [1:0] c_DIR_UP_RIGHT   = 2'b10;
    localparam logic [1:0] c_DIR_DOWN_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        COLL_NO       = 3'b000,
        COLL_L_PADDLE = 3'b001,
        COLL_R_PADDLE = 3'b010,
        COLL_TOP      = 3'b011,
        COLL_BOTTOM   = 3'b100
    } coll_t;

    typedef enum logic [2:0] {
        ST_SERVE     = 3'd0,
        ST_PLAY      = 3'd1,
        ST_COOLDOWN  = 3'd2,
        ST_MISS      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Unsigned 13-bit subtract that clamps at zero instead of wrapping
    function automatic logic [12:0] sat_sub(input logic [12:0] a, input logic [12:0] b);
        return (a > b) ? (a - b) : 13'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/paddle_hit_check.sv
// ============================================================================
// Module      : paddle_hit_check
// Description : Combinational paddle contact test. Flags when the ball's
//               leading edge lies inside the paddle's column window and the
//               ball centre is within reach of the paddle centre row.
//               Direction qualification and state masking are left to the
//               caller.
//   Parameters : IS_RIGHT      - 0 left paddle (edge = col-radius),
//                                1 right paddle (edge = col+radius)
//                FACE_COL      - outer face column of the paddle
//                PADDLE_WIDTH  - paddle thickness in columns
//                BALL_RADIUS   - ball half-width
//                PADDLE_HALF_H - paddle half-height
//   Ports      : i_ball_col, i_ball_row - ball centre
//                i_paddle_row           - paddle centre row
//                o_hit                  - contact geometry satisfied
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module paddle_hit_check
    import pong_pkg::*;
#(
    parameter int IS_RIGHT      = 0,
    parameter int FACE_COL      = 20,
    parameter int PADDLE_WIDTH  = 10,
    parameter int BALL_RADIUS   = 4,
    parameter int PADDLE_HALF_H = 40
) (
    input  logic [11:0] i_ball_col,
    input  logic [11:0] i_ball_row,
    input  logic [11:0] i_paddle_row,
    output logic        o_hit
);

    // The left paddle spans [face, face+width]; the right one mirrors it
    localparam logic [12:0] c_WIN_LO    = (IS_RIGHT != 0) ? 13'(FACE_COL - PADDLE_WIDTH) : 13'(FACE_COL);
    localparam logic [12:0] c_WIN_HI    = (IS_RIGHT != 0) ? 13'(FACE_COL) : 13'(FACE_COL + PADDLE_WIDTH);
    localparam logic [12:0] c_ROW_REACH = 13'(PADDLE_HALF_H + BALL_RADIUS);
    localparam logic [12:0] c_RADIUS    = 13'(BALL_RADIUS);

    logic [12:0] w_col;
    logic [12:0] w_row;
    logic [12:0] w_prow;
    logic [12:0] w_edge;
    logic [12:0] w_row_dist;

    assign w_col  = {1'b0, i_ball_col};
    assign w_row  = {1'b0, i_ball_row};
    assign w_prow = {1'b0, i_paddle_row};

    // Leading edge of the ball facing this paddle
    generate
        if (IS_RIGHT != 0) begin : g_right_edge
            assign w_edge = w_col + c_RADIUS;
        end else begin : g_left_edge
            assign w_edge = sat_sub(w_col, c_RADIUS);
        end
    endgenerate

    assign w_row_dist = (w_row >= w_prow) ? (w_row - w_prow) : (w_prow - w_row);

    assign o_hit = (w_edge >= c_WIN_LO) && (w_edge <= c_WIN_HI) && (w_row_dist <= c_ROW_REACH);

endmodule

`default_nettype wire

// File: rtl/ball_collision_ctrl.sv
// ============================================================================
// Module      : ball_collision_ctrl
// Description : Pong collision/score controller. On every frame tick it
//               checks the ball against the walls and both paddles, updates
//               the registered ball direction, pulses a collision code,
//               detects misses, keeps both scores and sequences serve and
//               game-over.
//   Ports : clk, rst_n (synchronous, active-low)
//           frame_tick                       - one-cycle pulse per ball step
//           ball_center_col/row              - ball centre position
//           l_paddle_row, r_paddle_row       - paddle centre rows
//           ball_direction [1:0]             - bit1 right, bit0 down
//           collision_type [2:0]             - one-cycle collision code
//           ball_reset                       - high while serving/game over
//           score_l, score_r [3:0]           - player scores
//           game_over                        - a score reached MAX_SCORE
//   Optional feature macro : BALL_COLLIS_SPIN_EN
//           When defined, a paddle hit sets the vertical direction from the
//           contact zone (upper third up, lower third down, middle kept).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_collision_ctrl
    import pong_pkg::*;
#(
    parameter int DISP_COLS      = 800,
    parameter int DISP_ROWS      = 600,
    parameter int BALL_RADIUS    = 4,
    parameter int PADDLE_HALF_H  = 40,
    parameter int PADDLE_MARGIN  = 20,
    parameter int PADDLE_WIDTH   = 10,
    parameter int COOLDOWN_TICKS = 8,
    parameter int SERVE_TICKS    = 60,
    parameter int MAX_SCORE      = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [11:0] ball_center_col,
    input  logic [11:0] ball_center_row,
    input  logic [11:0] l_paddle_row,
    input  logic [11:0] r_paddle_row,
    output logic [1:0]  ball_direction,
    output logic [2:0]  collision_type,
    output logic        ball_reset,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    localparam int          c_CNT_MAX      = (SERVE_TICKS > COOLDOWN_TICKS) ? SERVE_TICKS : COOLDOWN_TICKS;
    localparam int          c_CNT_W        = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_SERVE_LOAD = c_CNT_W'(SERVE_TICKS);
    localparam logic [c_CNT_W-1:0] c_COOL_LOAD  = c_CNT_W'(COOLDOWN_TICKS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [12:0] c_TOP_LIMIT    = 13'(BALL_RADIUS);
    localparam logic [12:0] c_BOTTOM_LIMIT = 13'(DISP_ROWS - 1 - BALL_RADIUS);
    localparam logic [12:0] c_LMISS_LIMIT  = 13'(BALL_RADIUS);
    localparam logic [12:0] c_RMISS_LIMIT  = 13'(DISP_COLS - 1 - BALL_RADIUS);
    localparam logic [3:0]  c_MAX_SCORE    = 4'(MAX_SCORE);
    localparam logic [3:0]  c_SCORE_ONE    = 4'd1;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_dir;
    coll_t              r_coll;
    logic               r_ball_reset;
    logic [3:0]         r_score_l;
    logic [3:0]         r_score_r;
    logic               r_game_over;
    logic               r_miss_left;

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    logic [12:0] w_col;
    logic [12:0] w_row;
    logic        w_l_raw;
    logic        w_r_raw;

    assign w_col = {1'b0, ball_center_col};
    assign w_row = {1'b0, ball_center_row};

    paddle_hit_check #(
        .IS_RIGHT      (0),
        .FACE_COL      (PADDLE_MARGIN),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .BALL_RADIUS   (BALL_RADIUS),
        .PADDLE_HALF_H (PADDLE_HALF_H)
    ) u_l_check (
        .i_ball_col   (ball_center_col),
        .i_ball_row   (ball_center_row),
        .i_paddle_row (l_paddle_row),
        .o_hit        (w_l_raw)
    );

    paddle_hit_check #(
        .IS_RIGHT      (1),
        .FACE_COL      (DISP_COLS - 1 - PADDLE_MARGIN),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .BALL_RADIUS   (BALL_RADIUS),
        .PADDLE_HALF_H (PADDLE_HALF_H)
    ) u_r_check (
        .i_ball_col   (ball_center_col),
        .i_ball_row   (ball_center_row),
        .i_paddle_row (r_paddle_row),
        .o_hit        (w_r_raw)
    );

    // Every check is direction-qualified so a ball already moving away is
    // never bounced twice.
    logic w_top;
    logic w_bottom;
    logic w_l_hit;
    logic w_r_hit;
    logic w_paddle_hit;
    logic w_l_miss;
    logic w_r_miss;

    assign w_top        = (w_row <= c_TOP_LIMIT)    && !r_dir[0];
    assign w_bottom     = (w_row >= c_BOTTOM_LIMIT) &&  r_dir[0];
    // Paddle checks are masked during cooldown
    assign w_l_hit      = (r_state == ST_PLAY) && !r_dir[1] && w_l_raw;
    assign w_r_hit      = (r_state == ST_PLAY) &&  r_dir[1] && w_r_raw;
    assign w_paddle_hit = w_l_hit || w_r_hit;
    assign w_l_miss     = (w_col <= c_LMISS_LIMIT) && !r_dir[1];
    assign w_r_miss     = (w_col >= c_RMISS_LIMIT) &&  r_dir[1];

`ifdef BALL_COLLIS_SPIN_EN
    localparam logic [12:0] c_THIRD = 13'(PADDLE_HALF_H / 3);

    logic [12:0] w_hit_prow;
    logic        w_spin_up;
    logic        w_spin_down;

    assign w_hit_prow  = w_l_hit ? {1'b0, l_paddle_row} : {1'b0, r_paddle_row};
    // Screen rows grow downward, so "upper" means a smaller row number
    assign w_spin_up   = (w_row + c_THIRD) < w_hit_prow;
    assign w_spin_down = w_row > (w_hit_prow + c_THIRD);
`endif

    // Direction and code for a tick with no miss. A paddle hit and a wall
    // hit on the same tick flip both bits; the paddle code is reported.
    logic [1:0] w_dir_next;
    coll_t      w_coll_next;

    always_comb begin
        w_dir_next  = r_dir;
        w_coll_next = COLL_NO;
        if (w_top) begin
            w_dir_next[0] = 1'b1;
            w_coll_next   = COLL_TOP;
        end else if (w_bottom) begin
            w_dir_next[0] = 1'b0;
            w_coll_next   = COLL_BOTTOM;
        end
        if (w_l_hit) begin
            w_dir_next[1] = 1'b1;
            w_coll_next   = COLL_L_PADDLE;
        end else if (w_r_hit) begin
            w_dir_next[1] = 1'b0;
            w_coll_next   = COLL_R_PADDLE;
        end
`ifdef BALL_COLLIS_SPIN_EN
        if (w_paddle_hit) begin
            if (w_spin_up) begin
                w_dir_next[0] = 1'b0;
            end else if (w_spin_down) begin
                w_dir_next[0] = 1'b1;
            end
        end
`endif
    end

    // Saturating score update for the player who won the point
    logic [3:0] w_old_score;
    logic [3:0] w_new_score;

    assign w_old_score = r_miss_left ? r_score_r : r_score_l;
    assign w_new_score = (w_old_score < c_MAX_SCORE) ? (w_old_score + c_SCORE_ONE) : w_old_score;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_SERVE;
            r_cnt        <= c_SERVE_LOAD;
            r_dir        <= c_DIR_DOWN_RIGHT;
            r_coll       <= COLL_NO;
            r_ball_reset <= 1'b1;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_game_over  <= 1'b0;
            r_miss_left  <= 1'b0;
        end else begin
            r_coll <= COLL_NO;
            case (r_state)
                ST_SERVE: begin
                    if (frame_tick) begin
                        // Play resumes on the tick that drains the counter
                        if (r_cnt <= c_CNT_ONE) begin
                            r_cnt        <= '0;
                            r_state      <= ST_PLAY;
                            r_ball_reset <= 1'b0;
                            r_dir[0]     <= ~r_dir[0];
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                end

                ST_PLAY, ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (w_l_miss || w_r_miss) begin
                            r_state     <= ST_MISS;
                            r_miss_left <= w_l_miss;
                        end else begin
                            r_dir  <= w_dir_next;
                            r_coll <= w_coll_next;
                            if (w_paddle_hit) begin
                                r_state <= ST_COOLDOWN;
                                r_cnt   <= c_COOL_LOAD;
                            end else if (r_state == ST_COOLDOWN) begin
                                if (r_cnt <= c_CNT_ONE) begin
                                    r_cnt   <= '0;
                                    r_state <= ST_PLAY;
                                end else begin
                                    r_cnt <= r_cnt - c_CNT_ONE;
                                end
                            end
                        end
                    end
                end

                ST_MISS: begin
                    if (r_miss_left) begin
                        r_score_r <= w_new_score;
                    end else begin
                        r_score_l <= w_new_score;
                    end
                    // Serve heads toward the player who conceded
                    r_dir[1]     <= ~r_miss_left;
                    r_ball_reset <= 1'b1;
                    if (w_new_score == c_MAX_SCORE) begin
                        r_state     <= ST_GAME_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= ST_SERVE;
                        r_cnt   <= c_SERVE_LOAD;
                    end
                end

                ST_GAME_OVER: begin
                    r_ball_reset <= 1'b1;
                    r_game_over  <= 1'b1;
                end

                default: begin
                    r_state      <= ST_SERVE;
                    r_cnt        <= c_SERVE_LOAD;
                    r_ball_reset <= 1'b1;
                end
            endcase
        end
    end

    assign ball_direction = r_dir;
    assign collision_type = r_coll;
    assign ball_reset     = r_ball_reset;
    assign score_l        = r_score_l;
    assign score_r        = r_score_r;
    assign game_over      = r_game_over;

endmodule

`default_nettype wire
